// File: rtl/dmem_arbiter.sv
// Two-port arbiter for a single-port synchronous data memory, one transaction in flight.
// Define DMEM_ARB_FIXED_PRIO_EN for fixed port-0 priority; default is round-robin.
module dmem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_valid,
  output logic              p0_ready,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_rsp_valid,
  output logic [DATA_W-1:0] p0_rsp_rdata,
  output logic              p0_rsp_err,
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_rsp_valid,
  output logic [DATA_W-1:0] p1_rsp_rdata,
  output logic              p1_rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  localparam bit ROUND_ROBIN = 1'b0;
`else
  localparam bit ROUND_ROBIN = 1'b1;
`endif

  state_t              state;
  logic                last_grant;
  logic                owner;
  logic                we_q;
  logic [3:0]          cnt;

  logic                any_valid;
  logic                grant;
  logic                accept;
  logic                req_we;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic                misaligned;
  logic                rsp_fire;
  logic                rsp_port;
  logic [DATA_W-1:0]   rsp_data;
  logic                rsp_err;

  // Grant selection: a lone requester wins; a tie goes to the port not served last.
  always_comb begin
    any_valid = p0_valid | p1_valid;
    grant     = 1'b0;
    if (p0_valid && p1_valid) begin
      grant = ROUND_ROBIN ? ~last_grant : 1'b0;
    end else if (p1_valid) begin
      grant = 1'b1;
    end
  end

  assign p0_ready = (state == IDLE) && any_valid && !grant;
  assign p1_ready = (state == IDLE) && any_valid && grant;
  assign accept   = p0_ready | p1_ready;

  assign req_we     = grant ? p1_we    : p0_we;
  assign req_addr   = grant ? p1_addr  : p0_addr;
  assign req_wdata  = grant ? p1_wdata : p0_wdata;
  assign misaligned = (req_addr[1:0] != 2'b00);

  // A response is produced either straight from IDLE (misaligned) or at the end of WAIT.
  always_comb begin
    rsp_fire = 1'b0;
    rsp_port = owner;
    rsp_data = '0;
    rsp_err  = 1'b0;
    if (state == IDLE && accept && misaligned) begin
      rsp_fire = 1'b1;
      rsp_port = grant;
      rsp_err  = 1'b1;
    end else if (state == WAIT && cnt == 4'd1) begin
      rsp_fire = 1'b1;
      rsp_data = we_q ? '0 : mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      owner        <= 1'b0;
      we_q         <= 1'b0;
      cnt          <= '0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      p0_rsp_valid <= 1'b0;
      p0_rsp_rdata <= '0;
      p0_rsp_err   <= 1'b0;
      p1_rsp_valid <= 1'b0;
      p1_rsp_rdata <= '0;
      p1_rsp_err   <= 1'b0;
    end else begin
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      p0_rsp_valid <= 1'b0;
      p1_rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            owner      <= grant;
            last_grant <= grant;
            we_q       <= req_we;
            if (misaligned) begin
              state <= RESP;
            end else begin
              state     <= ISSUE;
              mem_en    <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= req_addr[ADDR_W-1:2];
              mem_wdata <= req_wdata;
            end
          end
        end
        ISSUE: begin
          cnt   <= MEM_LAT[3:0];
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // Only the owner's response registers change, so the other port keeps its last result.
      if (rsp_fire) begin
        if (rsp_port) begin
          p1_rsp_valid <= 1'b1;
          p1_rsp_rdata <= rsp_data;
          p1_rsp_err   <= rsp_err;
        end else begin
          p0_rsp_valid <= 1'b1;
          p0_rsp_rdata <= rsp_data;
          p0_rsp_err   <= rsp_err;
        end
      end
    end
  end

endmodule
